// File: rtl/smj_ctrl.sv
// ---------------------------------------------------------------------------
// smj_ctrl
//
// Sequencing controller wrapped around the combinational SMJ hand evaluator.
// Tiles arrive one per valid/ready handshake and are assembled into a
// five-tile hand held in hand_n0..hand_n4. Once the hand is complete the
// controller spends one cycle letting SMJ settle, latches the 2-bit verdict,
// and offers it downstream under a second valid/ready handshake. SMJ itself
// stays purely combinational; all buffering and flow control live here.
//
// Parameters:
//   CNT_W      width of the completed-hand counter (only with the macro)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_tile carries a tile
//   in_tile    6-bit tile code, forwarded unmodified to SMJ
//   in_ready   controller accepts a tile this cycle (COLLECT only)
//   in_flush   synchronous abort of partial hand and pending verdict
//   hand_n0..4 registered hand, drives the SMJ inputs
//   smj_data   SMJ verdict, combinational from hand_n*
//   out_valid  out_data holds a verdict
//   out_data   latched SMJ verdict
//   out_ready  downstream accepts the verdict
//   hand_cnt   saturating count of delivered verdicts
//
// Optional feature:
//   SMJ_CTRL_HAND_CNT_EN  when defined, adds the hand_cnt port and counter.
// ---------------------------------------------------------------------------
module smj_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [5:0]       in_tile,
    output logic             in_ready,
    input  logic             in_flush,
    output logic [5:0]       hand_n0,
    output logic [5:0]       hand_n1,
    output logic [5:0]       hand_n2,
    output logic [5:0]       hand_n3,
    output logic [5:0]       hand_n4,
    input  logic [1:0]       smj_data,
    output logic             out_valid,
    output logic [1:0]       out_data,
    input  logic             out_ready
`ifdef SMJ_CTRL_HAND_CNT_EN
    ,
    output logic [CNT_W-1:0] hand_cnt
`endif
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic       accept;
    logic       handoff;

    assign in_ready = (state == COLLECT);

    // A tile offered in the same cycle as a flush is dropped, so flush
    // masks acceptance rather than just resetting idx afterwards.
    assign accept  = in_valid && in_ready && !in_flush;
    assign handoff = out_valid && out_ready;

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && (idx == 3'd4)) state_nxt = EVAL;
            EVAL:    state_nxt = OUT;
            OUT:     if (handoff) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
        if (in_flush) begin
            state_nxt = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Tile slot counter; wraps to 0 on the fifth tile so the next hand
    // starts at hand_n0 without a separate clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 3'd0;
        end else if (in_flush) begin
            idx <= 3'd0;
        end else if (accept) begin
            idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
    end

    // Hand registers only move on an accepted tile, which keeps the SMJ
    // inputs steady through EVAL and OUT. Flush leaves them alone; the
    // next hand simply overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hand_n0 <= 6'd0;
            hand_n1 <= 6'd0;
            hand_n2 <= 6'd0;
            hand_n3 <= 6'd0;
            hand_n4 <= 6'd0;
        end else if (accept) begin
            case (idx)
                3'd0:    hand_n0 <= in_tile;
                3'd1:    hand_n1 <= in_tile;
                3'd2:    hand_n2 <= in_tile;
                3'd3:    hand_n3 <= in_tile;
                default: hand_n4 <= in_tile;
            endcase
        end
    end

    // Verdict capture: SMJ has had the whole EVAL cycle to settle on the
    // registered hand, so its output is sampled at the end of EVAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 2'b00;
        end else if (in_flush) begin
            out_valid <= 1'b0;
        end else if (state == EVAL) begin
            out_valid <= 1'b1;
            out_data  <= smj_data;
        end else if (handoff) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SMJ_CTRL_HAND_CNT_EN
    // Delivered-hand counter. A handoff in a flush cycle still counts as
    // delivered; the counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hand_cnt <= '0;
        end else if (handoff && (hand_cnt != {CNT_W{1'b1}})) begin
            hand_cnt <= hand_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_smj_ctrl.sv
// ---------------------------------------------------------------------------
// tb_smj_ctrl
//
// Self-checking bench for smj_ctrl. A tiny SMJ stand-in returns the low two
// bits of (hand_n0 + hand_n4); expected verdicts are pushed to a queue when
// a hand is sent and popped by a monitor whenever a verdict is handed off.
// CNT_W is set to 2 so the saturating hand counter (macro builds) is easy
// to exercise.
// ---------------------------------------------------------------------------
module tb_smj_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] in_tile;
    logic       in_ready;
    logic       in_flush;
    logic [5:0] hand_n0, hand_n1, hand_n2, hand_n3, hand_n4;
    logic [1:0] smj_data;
    logic       out_valid;
    logic [1:0] out_data;
    logic       out_ready;
`ifdef SMJ_CTRL_HAND_CNT_EN
    logic [1:0] hand_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int verdicts = 0;
    int cyc      = 0;
    int last_acc = 0;
    int first_acc = 0;
    logic [1:0] sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SMJ stand-in: purely combinational from the registered hand.
    assign smj_data = 2'(hand_n0 + hand_n4);

    smj_ctrl #(.CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_tile   (in_tile),
        .in_ready  (in_ready),
        .in_flush  (in_flush),
        .hand_n0   (hand_n0),
        .hand_n1   (hand_n1),
        .hand_n2   (hand_n2),
        .hand_n3   (hand_n3),
        .hand_n4   (hand_n4),
        .smj_data  (smj_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef SMJ_CTRL_HAND_CNT_EN
        ,
        .hand_cnt  (hand_cnt)
`endif
    );

    // Scoreboard monitor: a verdict leaves the DUT on any edge where
    // out_valid && out_ready, so compare it half a cycle beforehand.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            verdicts++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL verdict_unexpected out_data=%b required=none", out_data);
            end else begin
                logic [1:0] exp_v;
                exp_v = sb.pop_front();
                if (out_data !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL verdict_data out_data=%b required=%b", out_data, exp_v);
                end
            end
        end
    end

    task automatic send_tile(input logic [5:0] t);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_tile  = t;
        while (in_ready !== 1'b1 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL tile_accept_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_hand(input logic [5:0] a, input logic [5:0] b,
                             input logic [5:0] c, input logic [5:0] d,
                             input logic [5:0] e);
        send_tile(a);
        first_acc = last_acc;
        send_tile(b);
        send_tile(c);
        send_tile(d);
        send_tile(e);
        sb.push_back(2'(a + e));
    endtask

    task automatic wait_out();
        int w;
        w = 0;
        while (out_valid !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (out_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL out_valid_timeout out_valid=%b required=1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_tile   = 6'd0;
        in_flush  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_data} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl {in_ready,out_valid,out_data}=%b required=1000",
                     {in_ready, out_valid, out_data});
        end
        n_checks++;
        if ({hand_n0, hand_n1, hand_n2, hand_n3, hand_n4} !== 30'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_hand hand=%h required=0",
                     {hand_n0, hand_n1, hand_n2, hand_n3, hand_n4});
        end
`ifdef SMJ_CTRL_HAND_CNT_EN
        n_checks++;
        if (hand_cnt !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_hand_cnt hand_cnt=%0d required=0", hand_cnt);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_hand(6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
        // One cycle after the fifth accept: EVAL, verdict not yet visible.
        n_checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL basic_eval {in_ready,out_valid}=%b required=00", {in_ready, out_valid});
        end
        n_checks++;
        if ({hand_n0, hand_n1, hand_n2, hand_n3, hand_n4} !== {6'd1, 6'd2, 6'd3, 6'd4, 6'd5}) begin
            n_fail++;
            $display("[TB] FAIL basic_hand hand=%h required=%h",
                     {hand_n0, hand_n1, hand_n2, hand_n3, hand_n4}, {6'd1, 6'd2, 6'd3, 6'd4, 6'd5});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, out_data, in_ready} !== 4'b1100) begin
            n_fail++;
            $display("[TB] FAIL basic_out {out_valid,out_data,in_ready}=%b required=1100",
                     {out_valid, out_data, in_ready});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL basic_handoff {out_valid,in_ready}=%b required=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send_hand(6'd20, 6'd21, 6'd22, 6'd23, 6'd24);
        wait_out();
        in_valid = 1'b1;
        in_tile  = 6'd63;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, out_data, in_ready} !== 4'b1000) begin
                n_fail++;
                $display("[TB] FAIL stall_hold cycle=%0d {out_valid,out_data,in_ready}=%b required=1000",
                         i, {out_valid, out_data, in_ready});
            end
        end
        n_checks++;
        if ({hand_n0, hand_n1, hand_n2, hand_n3, hand_n4} !== {6'd20, 6'd21, 6'd22, 6'd23, 6'd24}) begin
            n_fail++;
            $display("[TB] FAIL stall_hand hand=%h required=%h",
                     {hand_n0, hand_n1, hand_n2, hand_n3, hand_n4}, {6'd20, 6'd21, 6'd22, 6'd23, 6'd24});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL stall_release {out_valid,in_ready}=%b required=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_flush_partial();
        int v0;
        v0 = verdicts;
        out_ready = 1'b1;
        send_tile(6'd40);
        send_tile(6'd41);
        send_tile(6'd42);
        // Tile 50 would land in hand_n3 if the flush cycle accepted it.
        in_valid = 1'b1;
        in_tile  = 6'd50;
        in_flush = 1'b1;
        @(posedge clk); #1;
        in_flush = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, hand_n3, hand_n4} !== {1'b1, 6'd23, 6'd24}) begin
            n_fail++;
            $display("[TB] FAIL flush_discard {in_ready,hand_n3,hand_n4}=%h required=%h",
                     {in_ready, hand_n3, hand_n4}, {1'b1, 6'd23, 6'd24});
        end
        send_hand(6'd9, 6'd10, 6'd11, 6'd12, 6'd13);
        wait_out();
        @(posedge clk); #1;
        n_checks++;
        if (verdicts !== v0 + 1) begin
            n_fail++;
            $display("[TB] FAIL flush_verdict_count verdicts=%0d required=%0d", verdicts - v0, 1);
        end
        n_checks++;
        if ({hand_n0, hand_n1, hand_n2, hand_n3, hand_n4} !== {6'd9, 6'd10, 6'd11, 6'd12, 6'd13}) begin
            n_fail++;
            $display("[TB] FAIL flush_new_hand hand=%h required=%h",
                     {hand_n0, hand_n1, hand_n2, hand_n3, hand_n4}, {6'd9, 6'd10, 6'd11, 6'd12, 6'd13});
        end
    endtask

    task automatic test_flush_out();
`ifdef SMJ_CTRL_HAND_CNT_EN
        logic [1:0] hc0;
`endif
        out_ready = 1'b0;
        send_hand(6'd30, 6'd1, 6'd2, 6'd3, 6'd35);
        wait_out();
        n_checks++;
        if (out_data !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL flush_out_data out_data=%b required=01", out_data);
        end
`ifdef SMJ_CTRL_HAND_CNT_EN
        hc0 = hand_cnt;
`endif
        in_flush = 1'b1;
        @(posedge clk); #1;
        in_flush = 1'b0;
        // The pending verdict was never handed off, so it is abandoned.
        sb.delete();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL flush_out_state {out_valid,in_ready}=%b required=01", {out_valid, in_ready});
        end
`ifdef SMJ_CTRL_HAND_CNT_EN
        n_checks++;
        if (hand_cnt !== hc0) begin
            n_fail++;
            $display("[TB] FAIL flush_out_hand_cnt hand_cnt=%0d required=%0d", hand_cnt, hc0);
        end
`endif
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_tile(6'd7);
        send_tile(6'd8);
        send_tile(6'd9);
        send_tile(6'd10);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_data} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_ctrl {in_ready,out_valid,out_data}=%b required=1000",
                     {in_ready, out_valid, out_data});
        end
        n_checks++;
        if ({hand_n0, hand_n1, hand_n2, hand_n3, hand_n4} !== 30'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_hand hand=%h required=0",
                     {hand_n0, hand_n1, hand_n2, hand_n3, hand_n4});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_hand(6'd14, 6'd15, 6'd16, 6'd17, 6'd18);
        wait_out();
        @(posedge clk); #1;
        n_checks++;
        if ({hand_n0, hand_n1, hand_n2, hand_n3, hand_n4} !== {6'd14, 6'd15, 6'd16, 6'd17, 6'd18}) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_fresh_hand hand=%h required=%h",
                     {hand_n0, hand_n1, hand_n2, hand_n3, hand_n4}, {6'd14, 6'd15, 6'd16, 6'd17, 6'd18});
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] t[5];
        int prev_acc;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        prev_acc = 0;
        for (int h = 0; h < 5; h++) begin
            for (int i = 0; i < 5; i++) t[i] = 6'($urandom_range(0, 63));
            send_hand(t[0], t[1], t[2], t[3], t[4]);
            if (h > 0) begin
                n_checks++;
                if (first_acc - prev_acc !== 7) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_period hand=%0d cycles=%0d required=7", h, first_acc - prev_acc);
                end
            end
            prev_acc = first_acc;
`ifdef SMJ_CTRL_HAND_CNT_EN
            n_checks++;
            if (hand_cnt !== 2'((h > 3) ? 3 : h)) begin
                n_fail++;
                $display("[TB] FAIL b2b_hand_cnt hand=%0d hand_cnt=%0d required=%0d",
                         h, hand_cnt, (h > 3) ? 3 : h);
            end
`endif
        end
        wait_out();
        @(posedge clk); #1;
`ifdef SMJ_CTRL_HAND_CNT_EN
        n_checks++;
        if (hand_cnt !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL b2b_hand_cnt_sat hand_cnt=%0d required=3", hand_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush_partial();
        test_flush_out();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
